pll_lock_supervisor: RTL and testbench



---
 rtl/pll_lock_supervisor.sv | 148 ++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// Bring-up sequencer and run-time supervisor for the iCE40 SB_PLL40_CORE, clocked from the reference clock.
// Optional macro PLL_SUP_FAST_RELOCK_EN: loss of lock in RUN re-enters WAIT_LOCK without pulsing the PLL reset.
module pll_lock_supervisor #(
    parameter int CNT_W         = 16,
    parameter int RESET_CYCLES  = 48,
    parameter int LOCK_TIMEOUT  = 4800,
    parameter int STABLE_CYCLES = 480,
    parameter int LOSS_FILTER   = 3,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       pll_locked,
    output logic       pll_resetb,
    output logic       sys_reset,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [7:0] loss_count
);

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAULT
    } state_t;

    // Terminal timer values: a state timed by N cycles leaves when cnt reaches N-1.
    localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FILTER_LAST  = CNT_W'(LOSS_FILTER - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

`ifdef PLL_SUP_FAST_RELOCK_EN
    localparam state_t LOSS_TARGET = ST_WAIT_LOCK;
`else
    localparam state_t LOSS_TARGET = ST_PLL_RST;
`endif

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] filter;
    logic [CNT_W-1:0] filter_next;
    logic [3:0]       retries_next;
    logic [7:0]       loss_next;
    logic             lock_meta;
    logic             lock_s;

    // pll_locked is asynchronous to clock_in; nothing downstream looks at the raw pin.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state       <= ST_PLL_RST;
            cnt         <= '0;
            filter      <= '0;
            retry_count <= 4'd0;
            loss_count  <= 8'd0;
        end else begin
            state       <= next_state;
            cnt         <= (next_state != state) ? '0 : cnt + CNT_W'(1);
            filter      <= filter_next;
            retry_count <= retries_next;
            loss_count  <= loss_next;
        end
    end

    always_comb begin
        next_state   = state;
        retries_next = retry_count;
        filter_next  = '0;
        loss_next    = loss_count;
        case (state)
            ST_PLL_RST: begin
                if (cnt == RESET_LAST) begin
                    next_state = ST_WAIT_LOCK;
                end
            end
            // A lock seen on the timeout cycle still wins over the retry.
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    next_state = ST_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (retry_count == RETRY_MAX) begin
                        next_state = ST_FAULT;
                    end else begin
                        retries_next = retry_count + 4'd1;
                        next_state   = ST_PLL_RST;
                    end
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    next_state = ST_WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    next_state   = ST_RUN;
                    retries_next = 4'd0;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    if (filter == FILTER_LAST) begin
                        next_state = LOSS_TARGET;
                        if (loss_count != 8'hFF) begin
                            loss_next = loss_count + 8'd1;
                        end
                    end else begin
                        filter_next = filter + CNT_W'(1);
                    end
                end
            end
            ST_FAULT: begin
                next_state = ST_FAULT;
            end
            default: begin
                next_state = ST_PLL_RST;
            end
        endcase
    end

    // Outputs are decoded from next_state into flops so they line up with state and never see pll_locked directly.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            pll_resetb <= 1'b0;
            sys_reset  <= 1'b1;
            ready      <= 1'b0;
            fault      <= 1'b0;
        end else begin
            pll_resetb <= !((next_state == ST_PLL_RST) || (next_state == ST_FAULT));
            sys_reset  <= (next_state != ST_RUN);
            ready      <= (next_state == ST_RUN);
            fault      <= (next_state == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: directed stimulus queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pll_lock_supervisor;

    localparam int CNT_W         = 16;
    localparam int RESET_CYCLES  = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int LOSS_FILTER   = 3;
    localparam int MAX_RETRIES   = 2;

    logic       clock_in = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_resetb;
    logic       sys_reset;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;
    logic [7:0] loss_count;

    pll_lock_supervisor #(
        .CNT_W        (CNT_W),
        .RESET_CYCLES (RESET_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .LOSS_FILTER  (LOSS_FILTER),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .pll_locked (pll_locked),
        .pll_resetb (pll_resetb),
        .sys_reset  (sys_reset),
        .ready      (ready),
        .fault      (fault),
        .retry_count(retry_count),
        .loss_count (loss_count)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        int         cyc;
        byte        st;
        logic [3:0] retry;
        logic [7:0] loss;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   t0 = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clock_in) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock_in);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic locked, input logic rst);
        pll_locked = locked;
        reset      = rst;
    endtask

    // State letters: R=PLL_RST W=WAIT_LOCK S=STABLE U=RUN F=FAULT.
    task automatic checkOutput(input string name, input byte st, input logic [3:0] retry, input logic [7:0] loss);
        exp_t e;
        e.cyc   = cyc;
        e.st    = st;
        e.retry = retry;
        e.loss  = loss;
        e.name  = name;
        sb_q.push_back(e);
    endtask

    task automatic doReset(input logic locked);
        applyStimulus(locked, 1'b1);
        tick(1);
        applyStimulus(locked, 1'b0);
        t0 = cyc;
    endtask

    // Monitor: every output vector due this cycle is compared against the DUT at the falling edge.
    always @(negedge clock_in) begin : monitor
        exp_t e;
        logic [15:0] want;
        logic [15:0] got;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e    = sb_q.pop_front();
            want = {!((e.st == "R") || (e.st == "F")), (e.st != "U"), (e.st == "U"), (e.st == "F"),
                    e.retry, e.loss};
            got  = {pll_resetb, sys_reset, ready, fault, retry_count, loss_count};
            vectors++;
            if (e.cyc != cyc || got !== want) begin
                miscompares++;
                $display("[TB] FAIL %s rel=%0d: got resetb=%b sys_reset=%b ready=%b fault=%b retry=%0d loss=%0d, want resetb=%b sys_reset=%b ready=%b fault=%b retry=%0d loss=%0d",
                         e.name, e.cyc - t0, got[15], got[14], got[13], got[12], got[11:8], got[7:0],
                         want[15], want[14], want[13], want[12], want[11:8], want[7:0]);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, want $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Clean bring-up with lock already present: ready at rel 13.
    task automatic runNominal(input string name);
        byte st;
        doReset(1'b1);
        for (int r = 0; r <= 14; r++) begin
            if (r < 4)       st = "R";
            else if (r < 5)  st = "W";
            else if (r < 13) st = "S";
            else             st = "U";
            checkOutput(name, st, 4'd0, 8'd0);
            tick(1);
        end
    endtask

    initial begin : stimulus
        byte st;
        logic [3:0] rc;
        logic [7:0] lc;
        int base;

        applyStimulus(1'b1, 1'b1);
        tick(2);

        $display("[TB] scenario 1: nominal bring-up");
        runNominal("nominal");

        $display("[TB] scenario 2: no lock, retries then fault");
        doReset(1'b0);
        for (int r = 0; r <= 90; r++) begin
            if (r == 75) pll_locked = 1'b1;
            if (r < 4)       st = "R";
            else if (r < 24) st = "W";
            else if (r < 28) st = "R";
            else if (r < 48) st = "W";
            else if (r < 52) st = "R";
            else if (r < 72) st = "W";
            else             st = "F";
            if (r < 24)      rc = 4'd0;
            else if (r < 48) rc = 4'd1;
            else             rc = 4'd2;
            checkOutput("retry_fault", st, rc, 8'd0);
            tick(1);
        end

        $display("[TB] scenario 3: glitch filter and loss of lock");
        doReset(1'b1);
        for (int r = 0; r <= 50; r++) begin
            if (r == 16 || r == 30) pll_locked = 1'b0;
            if (r == 18 || r == 33) pll_locked = 1'b1;
            if (r < 4)       st = "R";
            else if (r < 5)  st = "W";
            else if (r < 13) st = "S";
            else if (r < 35) st = "U";
            else if (r < 39) st = "R";
            else if (r < 40) st = "W";
            else if (r < 48) st = "S";
            else             st = "U";
            lc = (r < 35) ? 8'd0 : 8'd1;
            checkOutput("loss_filter", st, 4'd0, lc);
            tick(1);
        end

        $display("[TB] scenario 5: reset from RUN clears loss_count");
        runNominal("reset_in_run");

        $display("[TB] scenario 4: lock drop during STABLE");
        doReset(1'b1);
        for (int r = 0; r <= 24; r++) begin
            if (r == 10) pll_locked = 1'b0;
            if (r == 11) pll_locked = 1'b1;
            if (r < 4)       st = "R";
            else if (r < 5)  st = "W";
            else if (r < 13) st = "S";
            else if (r < 14) st = "W";
            else if (r < 22) st = "S";
            else             st = "U";
            checkOutput("stable_drop", st, 4'd0, 8'd0);
            tick(1);
        end

        $display("[TB] scenario 6: loss_count saturation");
        doReset(1'b1);
        tick(14);
        checkOutput("sat_start", "U", 4'd0, 8'd0);
        for (int i = 0; i < 256; i++) begin
            base = cyc;
            lc = (i >= 255) ? 8'd255 : 8'(i + 1);
            pll_locked = 1'b0;
            tick(3);
            pll_locked = 1'b1;
            tick(2);
            if (cyc - base == 5) checkOutput("sat_relock_rst", "R", 4'd0, lc);
            tick(13);
            checkOutput("sat_run", "U", 4'd0, lc);
        end

        tick(1);
        @(negedge clock_in);
        #1;
        if (sb_q.size() != 0) begin
            $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
            miscompares += sb_q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
